// File: rtl/palette_lut.sv
// Writable colour palette with an init sweep, a write-first lookup bypass and a
// two-stage lookup pipeline that scales each channel by a global brightness.
module palette_lut #(
  parameter int                INDEX_W    = 8,
  parameter int                DEPTH      = 256,
  parameter int                CH_W       = 8,
  parameter int                TRANSP_IDX = 0,
  parameter logic [3*CH_W-1:0] INIT_COLOR = '0
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 in_valid,
  input  logic [INDEX_W-1:0]   index,
  input  logic [7:0]           brightness,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_addr,
  input  logic [3*CH_W-1:0]    wr_data,
  output logic                 busy,
  output logic                 out_valid,
  output logic [3*CH_W-1:0]    RGB,
  output logic                 transparent
);

  localparam int RGB_W  = 3 * CH_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int PROD_W = CH_W + 9;

  localparam logic [INDEX_W:0]   DEPTH_L  = (INDEX_W + 1)'(DEPTH);
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(DEPTH - 1);
  localparam logic [INDEX_W-1:0] TRANSP_L = INDEX_W'(TRANSP_IDX);

  // Handshake: a lookup is taken every cycle in_valid is high (no backpressure);
  // out_valid marks RGB/transparent two cycles later, and they hold while it is low.

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;

  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [RGB_W-1:0]   mem_wdata;
  logic [RGB_W-1:0]   mem_q [DEPTH];

  logic               wr_in_range;
  logic               rd_in_range;
  logic [RGB_W-1:0]   rd_data;

  logic               s1_valid_q, s1_valid_d;
  logic [INDEX_W-1:0] s1_index_q, s1_index_d;
  logic [7:0]         s1_bright_q, s1_bright_d;
  logic [RGB_W-1:0]   s1_color_q, s1_color_d;

  logic               out_valid_q, out_valid_d;
  logic [RGB_W-1:0]   rgb_q, rgb_d;
  logic               transp_q, transp_d;
  logic [RGB_W-1:0]   rgb_scaled;

  // c_out = (c * (brightness + 1)) >> 8, so 255 is exact unity gain.
  function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] c,
                                               input logic [7:0]      b);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'({1'b0, b} + 9'd1);
    return CH_W'(prod >> 8);
  endfunction

  assign busy        = (state_q == ST_INIT);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, index} < DEPTH_L);
  assign rd_data     = mem_q[index[AW-1:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      if (cnt_q == LAST_IDX) begin
        state_d = ST_RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The sweep owns the write port while busy; user writes are dropped then.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q[AW-1:0];
    mem_wdata = INIT_COLOR;
    if (state_q == ST_INIT) begin
      mem_we = 1'b1;
    end else if (wr_en && wr_in_range) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr[AW-1:0];
      mem_wdata = wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    s1_valid_d  = in_valid;
    s1_index_d  = index;
    s1_bright_d = brightness;
    if (state_q == ST_INIT) begin
      s1_color_d = INIT_COLOR;
    end else if (!rd_in_range) begin
      s1_color_d = '0;
    end else if (wr_en && wr_in_range && (wr_addr == index)) begin
      s1_color_d = wr_data;
    end else begin
      s1_color_d = rd_data;
    end
  end

  always_comb begin
    rgb_scaled = '0;
    for (int ch = 0; ch < 3; ch++) begin
      rgb_scaled[ch*CH_W +: CH_W] = scale_ch(s1_color_q[ch*CH_W +: CH_W], s1_bright_q);
    end
  end

  always_comb begin
    out_valid_d = s1_valid_q;
    rgb_d       = rgb_q;
    transp_d    = transp_q;
    if (s1_valid_q) begin
      rgb_d    = rgb_scaled;
      transp_d = (s1_index_q == TRANSP_L);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_index_q  <= '0;
      s1_bright_q <= '0;
      s1_color_q  <= '0;
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
      transp_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_index_q  <= s1_index_d;
      s1_bright_q <= s1_bright_d;
      s1_color_q  <= s1_color_d;
      out_valid_q <= out_valid_d;
      rgb_q       <= rgb_d;
      transp_q    <= transp_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign RGB         = rgb_q;
  assign transparent = transp_q;

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: init sweep, writes, bypass, scaling,
// streaming and asynchronous reset during a stream.
module tb_palette_lut;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        in_valid;
  logic [7:0]  index;
  logic [7:0]  brightness;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        out_valid;
  logic [23:0] RGB;
  logic        transparent;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  always #5 Clk = ~Clk;

  palette_lut dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .in_valid    (in_valid),
    .index       (index),
    .brightness  (brightness),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .out_valid   (out_valid),
    .RGB         (RGB),
    .transparent (transparent)
  );

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid   = 1'b0;
    index      = 8'd0;
    brightness = 8'd255;
    wr_en      = 1'b0;
    wr_addr    = 8'd0;
    wr_data    = 24'd0;
  endtask

  task automatic write_entry(input logic [7:0] a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick;
    wr_en   = 1'b0;
  endtask

  // Request in one cycle; outputs are ready to sample on return.
  task automatic lookup(input logic [7:0] idx, input logic [7:0] br);
    in_valid   = 1'b1;
    index      = idx;
    brightness = br;
    tick;
    in_valid   = 1'b0;
    tick;
  endtask

  task automatic wait_not_busy(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      tick;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset;
    idle_inputs;
    Reset_n = 1'b0;
    #12;
    checks += 4;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (RGB !== 24'h000000) begin errors++; $display("FAIL reset_rgb: got %h want 000000", RGB); end
    if (transparent !== 1'b0) begin errors++; $display("FAIL reset_transp: got %b want 0", transparent); end
    tick;
    Reset_n = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      tick;
      if (i == 1 || i == 255) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL init_busy_edge%0d: got %b want 1", i, busy); end
      end
      if (i == 256) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL init_done_edge256: got %b want 0", busy); end
      end
    end
  endtask

  task automatic test_init_readback;
    for (int i = 0; i <= 257; i++) begin
      if (i < 256) begin
        in_valid   = 1'b1;
        index      = 8'(i);
        brightness = 8'd255;
      end else begin
        in_valid = 1'b0;
      end
      tick;
      if (i >= 1 && i <= 256) begin
        checks++;
        if ({out_valid, transparent, RGB} !== {1'b1, (i == 1), 24'h000000}) begin
          errors++;
          $display("FAIL readback_idx%0d: got v=%b t=%b rgb=%h want v=1 t=%b rgb=000000",
                   i - 1, out_valid, transparent, RGB, (i == 1));
        end
      end else if (i == 257) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL readback_tail_valid: got %b want 0", out_valid); end
      end
    end
  endtask

  task automatic test_write_lookup;
    write_entry(8'd5, 24'h91ae51);
    lookup(8'd5, 8'd255);
    checks++;
    if ({out_valid, transparent, RGB} !== {1'b1, 1'b0, 24'h91ae51}) begin
      errors++;
      $display("FAIL lookup5: got v=%b t=%b rgb=%h want v=1 t=0 rgb=91ae51", out_valid, transparent, RGB);
    end
    lookup(8'd0, 8'd255);
    checks++;
    if ({out_valid, transparent, RGB} !== {1'b1, 1'b1, 24'h000000}) begin
      errors++;
      $display("FAIL lookup0_transp: got v=%b t=%b rgb=%h want v=1 t=1 rgb=000000", out_valid, transparent, RGB);
    end
    lookup(8'd5, 8'd127);
    checks++;
    if (RGB !== 24'h485728) begin errors++; $display("FAIL lookup5_b127: got %h want 485728", RGB); end
    write_entry(8'd200, 24'hdeadbe);
    lookup(8'd200, 8'd255);
    checks++;
    if (RGB !== 24'hdeadbe) begin errors++; $display("FAIL lookup200: got %h want deadbe", RGB); end
  endtask

  task automatic test_bypass;
    in_valid   = 1'b1;
    index      = 8'd9;
    brightness = 8'd255;
    wr_en      = 1'b1;
    wr_addr    = 8'd9;
    wr_data    = 24'hffffff;
    tick;
    in_valid = 1'b0;
    wr_en    = 1'b0;
    tick;
    checks++;
    if ({out_valid, RGB} !== {1'b1, 24'hffffff}) begin
      errors++;
      $display("FAIL bypass9: got v=%b rgb=%h want v=1 rgb=ffffff", out_valid, RGB);
    end
    lookup(8'd9, 8'd200);
    checks++;
    if (RGB !== 24'hc8c8c8) begin errors++; $display("FAIL lookup9_b200: got %h want c8c8c8", RGB); end
  endtask

  task automatic test_brightness;
    write_entry(8'd3, 24'h804020);
    lookup(8'd3, 8'd127);
    checks++;
    if (RGB !== 24'h402010) begin errors++; $display("FAIL bright127: got %h want 402010", RGB); end
    lookup(8'd3, 8'd0);
    checks++;
    if (RGB !== 24'h000000) begin errors++; $display("FAIL bright0: got %h want 000000", RGB); end
    lookup(8'd3, 8'd255);
    checks++;
    if (RGB !== 24'h804020) begin errors++; $display("FAIL bright255: got %h want 804020", RGB); end
  endtask

  task automatic test_back_to_back;
    write_entry(8'd6, 24'h111111);
    write_entry(8'd6, 24'h222222);
    lookup(8'd6, 8'd255);
    checks++;
    if (RGB !== 24'h222222) begin errors++; $display("FAIL b2b_last_wins: got %h want 222222", RGB); end
    write_entry(8'd6, 24'h333333);
    in_valid   = 1'b1;
    index      = 8'd6;
    brightness = 8'd255;
    tick;
    in_valid = 1'b0;
    write_entry(8'd6, 24'h444444);
    checks++;
    if ({out_valid, RGB} !== {1'b1, 24'h333333}) begin
      errors++;
      $display("FAIL b2b_between: got v=%b rgb=%h want v=1 rgb=333333", out_valid, RGB);
    end
    lookup(8'd6, 8'd255);
    checks++;
    if (RGB !== 24'h444444) begin errors++; $display("FAIL b2b_final: got %h want 444444", RGB); end
  endtask

  task automatic test_stream;
    logic [23:0] tbl [4];
    logic [23:0] exp_rgb;
    tbl[0] = 24'h0a0b0c;
    tbl[1] = 24'h102030;
    tbl[2] = 24'h804020;
    tbl[3] = 24'hff0000;
    for (int i = 0; i < 4; i++) write_entry(8'(i + 1), tbl[i]);
    exp_q.delete();
    for (int k = 0; k <= 5; k++) begin
      if (k < 4) begin
        in_valid   = 1'b1;
        index      = 8'(k + 1);
        brightness = 8'd255;
        exp_q.push_back(tbl[k]);
      end else begin
        in_valid = 1'b0;
      end
      tick;
      if (k >= 1 && k <= 4) begin
        exp_rgb = exp_q.pop_front();
        checks++;
        if ({out_valid, RGB} !== {1'b1, exp_rgb}) begin
          errors++;
          $display("FAIL stream_%0d: got v=%b rgb=%h want v=1 rgb=%h", k, out_valid, RGB, exp_rgb);
        end
      end else if (k == 5) begin
        checks++;
        if ({out_valid, RGB} !== {1'b0, 24'hff0000}) begin
          errors++;
          $display("FAIL stream_hold: got v=%b rgb=%h want v=0 rgb=ff0000", out_valid, RGB);
        end
      end
    end
  endtask

  task automatic test_init_write;
    Reset_n = 1'b0;
    #3;
    Reset_n = 1'b1;
    for (int i = 0; i < 100; i++) tick;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL init2_busy: got %b want 1", busy); end
    write_entry(8'd7, 24'h123456);
    lookup(8'd200, 8'd255);
    checks++;
    if ({out_valid, RGB} !== {1'b1, 24'h000000}) begin
      errors++;
      $display("FAIL lookup_during_init: got v=%b rgb=%h want v=1 rgb=000000", out_valid, RGB);
    end
    wait_not_busy(300, "init2_timeout");
    lookup(8'd7, 8'd255);
    checks++;
    if (RGB !== 24'h000000) begin errors++; $display("FAIL init_write_dropped: got %h want 000000", RGB); end
    lookup(8'd5, 8'd255);
    checks++;
    if (RGB !== 24'h000000) begin errors++; $display("FAIL init_overwrite5: got %h want 000000", RGB); end
  endtask

  task automatic test_reset_mid_stream;
    write_entry(8'd1, 24'h0a0b0c);
    write_entry(8'd3, 24'h804020);
    in_valid   = 1'b1;
    brightness = 8'd255;
    index      = 8'd1;
    tick;
    index = 8'd2;
    tick;
    checks++;
    if ({out_valid, RGB} !== {1'b1, 24'h0a0b0c}) begin
      errors++;
      $display("FAIL mid_pre_reset: got v=%b rgb=%h want v=1 rgb=0a0b0c", out_valid, RGB);
    end
    index = 8'd3;
    #2;
    Reset_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    if (RGB !== 24'h000000) begin errors++; $display("FAIL mid_reset_rgb: got %h want 000000", RGB); end
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_reset_busy: got %b want 1", busy); end
    if (transparent !== 1'b0) begin errors++; $display("FAIL mid_reset_transp: got %b want 0", transparent); end
    in_valid = 1'b0;
    tick;
    tick;
    Reset_n = 1'b1;
    tick;
    tick;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_flushed: got %b want 0", out_valid); end
    wait_not_busy(300, "init3_timeout");
    lookup(8'd3, 8'd255);
    checks++;
    if (RGB !== 24'h000000) begin errors++; $display("FAIL mid_after3: got %h want 000000", RGB); end
    lookup(8'd1, 8'd255);
    checks++;
    if ({out_valid, RGB} !== {1'b1, 24'h000000}) begin
      errors++;
      $display("FAIL mid_after1: got v=%b rgb=%h want v=1 rgb=000000", out_valid, RGB);
    end
  endtask

  initial begin
    test_reset;
    test_init_readback;
    test_write_lookup;
    test_bypass;
    test_brightness;
    test_back_to_back;
    test_stream;
    test_init_write;
    test_reset_mid_stream;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/palette_lut.md
# palette_lut

Programmable, pipelined colour palette for the VGA drawing path. It maps a per-pixel colour index to a 3-channel RGB value through a writable lookup RAM. The output is scaled by a global brightness factor and carries a transparency flag, so sprite layers can be composited over the background. It sits between the sprite/background pixel fetch and the final colour mux, and it replaces fixed hard-coded palettes.

## Interface
- INDEX_W, 8, width of colour index
- DEPTH, 256, number of palette entries (≤ 2^INDEX_W)
- CH_W, 8, bits per colour channel; RGB is 3*CH_W, packed {R,G,B}
- TRANSP_IDX, 0, index reported as transparent
- INIT_COLOR, 24'h000000 (3*CH_W bits), value every entry takes after reset
- Clk  in  1  system clock, all logic on rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  lookup request this cycle
- index  in  INDEX_W  colour index to look up
- brightness  in  8  global scale, 255 = unity, sampled with index
- wr_en  in  1  palette write strobe
- wr_addr  in  INDEX_W  entry to write
- wr_data  in  3*CH_W  new entry value
- busy  out  1  high while init sweep runs; writes ignored
- out_valid  out  1  RGB/transparent valid
- RGB  out  3*CH_W  scaled colour
- transparent  out  1  looked-up index == TRANSP_IDX

## Operation
- FSM states are INIT and RUN.
  - Reset enters INIT with the sweep counter at 0.
  - INIT writes INIT_COLOR to entry[counter], one entry per cycle, and increments the counter.
  - After the write of entry DEPTH-1, the FSM moves to RUN. It stays in RUN until the next reset.
- busy = (state == INIT).
- Writes: in RUN, wr_en=1 writes wr_data to entry[wr_addr]. wr_addr ≥ DEPTH writes are dropped. wr_en during INIT is dropped silently.
- Lookup stage 1 (registered): reads entry[index] and registers index, brightness and in_valid.
  - index ≥ DEPTH yields colour 0.
  - If busy, the colour is INIT_COLOR regardless of index.
  - Same-cycle write to the same address in RUN bypasses: stage 1 captures wr_data (write-first).
- Lookup stage 2 (registered): each channel is scaled as c_out = (c × (brightness+1)) >> 8.
  - Use a CH_W+9-bit product, truncated to CH_W bits.
  - brightness=255 gives c_out = c exactly. brightness=0 gives c_out = c>>8, which is 0 for CH_W=8.
  - transparent = (stage-1 index == TRANSP_IDX), evaluated independent of colour, brightness and busy.
- Lookups are fully pipelined: one accepted per cycle, no backpressure.
- Reset values: busy=1, out_valid=0, RGB=0, transparent=0. All pipeline valids are cleared.

## Timing
- Request at edge t (in_valid=1) gives out_valid=1 with RGB/transparent at edge t+2. Latency is 2, throughput is 1 per cycle.
- in_valid=0 at t gives out_valid=0 at t+2. RGB/transparent hold their last value while out_valid=0.
- A write at edge t is visible to a lookup sampled at edge t (bypass) and at any later edge.
- Init takes exactly DEPTH cycles: busy falls after the DEPTH-th rising edge following Reset_n deassertion.
- Reset_n asserted mid-operation:
  - Immediately forces out_valid=0, RGB=0 and busy=1.
  - In-flight lookups are discarded, and the FSM restarts INIT from entry 0.
  - Previous palette contents are overwritten by the sweep.
- Back-to-back writes to the same address: the last one wins. A lookup between the writes sees the value current at its sample edge.

## Test plan
- Reset, then hold in_valid=0 -> busy high for exactly DEPTH=256 cycles. Afterwards, lookups of indices 0..255 all return 24'h000000 with out_valid at t+2.
- In RUN, write entry 5 = 24'h91ae51, then look up 5 with brightness=255 -> RGB=24'h91ae51 two cycles later. Index 5 gives transparent=0; index 0 gives transparent=1.
- Write entry 9 = 24'hffffff and look up index 9 in the same cycle -> RGB=24'hffffff at t+2 (bypass). Writing 24'h123456 during INIT leaves the entry at INIT_COLOR.
- Entry 3 = 24'h804020 looked up with brightness 127, 0 and 255 -> 24'h402010, 24'h000000 and 24'h804020 respectively.
- Stream indices 1,2,3,4 with in_valid high for 4 consecutive cycles -> out_valid high for 4 consecutive cycles starting at t+2, colours in order. Assert Reset_n low during the stream -> out_valid drops at once, busy=1, and later lookups read 0.
